// File: rtl/protect_trip_latch.sv
// Fault trip latch: latches any active-low filtered fault, kills PWM, interrupts DSP, re-arms after clear handshake + hold-off.
// Optional trip counter output Trip_Cnt is enabled by defining PROTECT_TRIP_CNT_EN.
module protect_trip_latch #(
    parameter int unsigned CLR_MIN     = 4,
    parameter int unsigned HOLDOFF_CYC = 500
) (
    input  logic       CLK_50M,
    input  logic       Rst,
    input  logic       BusOvp_F,
    input  logic       IP_Ocp_F,
    input  logic       InvOcp1_F,
    input  logic       InvOcp2_F,
    input  logic       OP_Ovp1_F,
    input  logic       OP_Ovp2_F,
    input  logic       Fault_Clr,
    output logic       PWM_Kill_n,
    output logic       Fault_n,
    output logic       Clr_Ack,
    output logic [2:0] First_Code,
    output logic [5:0] Fault_Mask
`ifdef PROTECT_TRIP_CNT_EN
    ,
    output logic [7:0] Trip_Cnt
`endif
);

    typedef enum logic [1:0] {
        ST_ARMED    = 2'd0,
        ST_TRIPPED  = 2'd1,
        ST_CLEARING = 2'd2,
        ST_HOLDOFF  = 2'd3
    } state_t;

    state_t      r_state;
    logic [7:0]  r_clr_cnt;
    logic [15:0] r_hold_cnt;

    state_t      w_state_nxt;
    logic [7:0]  w_clr_cnt_nxt;
    logic [15:0] w_hold_cnt_nxt;
    logic [2:0]  w_code_nxt;
    logic [5:0]  w_mask_nxt;
    logic [5:0]  w_act;
    logic        w_any;
    logic [2:0]  w_first;

    // Index 0 is code 1 (BusOvp) through index 5 = code 6 (OP_Ovp2).
    assign w_act = ~{OP_Ovp2_F, OP_Ovp1_F, InvOcp2_F, InvOcp1_F, IP_Ocp_F, BusOvp_F};
    assign w_any = |w_act;

    always_comb begin
        w_first = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (w_act[i]) w_first = 3'(i + 1);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_cnt_nxt  = r_clr_cnt;
        w_hold_cnt_nxt = r_hold_cnt;
        w_code_nxt     = First_Code;
        w_mask_nxt     = Fault_Mask;
        unique case (r_state)
            ST_ARMED: begin
                if (w_any) begin
                    w_state_nxt   = ST_TRIPPED;
                    w_code_nxt    = w_first;
                    w_mask_nxt    = w_act;
                    w_clr_cnt_nxt = 8'd0;
                end
            end
            ST_TRIPPED: begin
                w_mask_nxt = Fault_Mask | w_act;
                if (!Fault_Clr)
                    w_clr_cnt_nxt = 8'd0;
                else if (r_clr_cnt >= 8'(CLR_MIN))
                    w_clr_cnt_nxt = 8'(CLR_MIN);
                else
                    w_clr_cnt_nxt = r_clr_cnt + 8'd1;
                // An accepted clear only takes effect once every fault has gone away.
                if (w_clr_cnt_nxt == 8'(CLR_MIN) && !w_any) begin
                    w_state_nxt   = ST_CLEARING;
                    w_code_nxt    = 3'd0;
                    w_mask_nxt    = 6'd0;
                    w_clr_cnt_nxt = 8'd0;
                end
            end
            ST_CLEARING: begin
                if (w_any) begin
                    w_state_nxt   = ST_TRIPPED;
                    w_code_nxt    = w_first;
                    w_mask_nxt    = w_act;
                    w_clr_cnt_nxt = 8'd0;
                end else if (!Fault_Clr) begin
                    w_state_nxt    = ST_HOLDOFF;
                    w_hold_cnt_nxt = 16'd0;
                end
            end
            ST_HOLDOFF: begin
                if (w_any) begin
                    w_state_nxt    = ST_TRIPPED;
                    w_code_nxt     = w_first;
                    w_mask_nxt     = w_act;
                    w_clr_cnt_nxt  = 8'd0;
                    w_hold_cnt_nxt = 16'd0;
                end else if (r_hold_cnt == 16'(HOLDOFF_CYC - 1)) begin
                    w_state_nxt    = ST_ARMED;
                    w_hold_cnt_nxt = 16'd0;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt   = ST_TRIPPED;
                w_mask_nxt    = Fault_Mask | w_act;
                w_clr_cnt_nxt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge CLK_50M) begin
        if (Rst) begin
            r_state    <= ST_HOLDOFF;
            r_clr_cnt  <= 8'd0;
            r_hold_cnt <= 16'd0;
            PWM_Kill_n <= 1'b0;
            Fault_n    <= 1'b1;
            Clr_Ack    <= 1'b0;
            First_Code <= 3'd0;
            Fault_Mask <= 6'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_cnt  <= w_clr_cnt_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            PWM_Kill_n <= (w_state_nxt == ST_ARMED);
            Fault_n    <= (w_state_nxt != ST_TRIPPED);
            Clr_Ack    <= (w_state_nxt == ST_CLEARING);
            First_Code <= w_code_nxt;
            Fault_Mask <= w_mask_nxt;
        end
    end

`ifdef PROTECT_TRIP_CNT_EN
    logic w_trip_evt;
    // Re-trips out of CLEARING are deliberately not counted.
    assign w_trip_evt = (w_state_nxt == ST_TRIPPED) &&
                        (r_state == ST_ARMED || r_state == ST_HOLDOFF);

    always_ff @(posedge CLK_50M) begin
        if (Rst)
            Trip_Cnt <= 8'd0;
        else if (w_trip_evt && Trip_Cnt != 8'hFF)
            Trip_Cnt <= Trip_Cnt + 8'd1;
    end
`endif

endmodule

// File: doc/protect_trip_latch.md
Name: protect_trip_latch

Overview:
- Consumer end of the filtered-fault interface: takes the six debounced, active-low fault flags and latches any fault.
- On a fault it forces the gate-driver kill line and raises an active-low interrupt to the DSP.
- It records which fault came first and which faults accumulated.
- Re-arm needs a DSP clear handshake followed by a hold-off interval.

Parameters:
- CLR_MIN, 4, consecutive cycles Fault_Clr must be high to be accepted (range 1..255).
- HOLDOFF_CYC, 500, cycles held in HOLDOFF before re-arm (10 us at 50 MHz; range 1..65535).

Ports:
- CLK_50M  in  1  system clock, 50 MHz
- Rst  in  1  synchronous reset, active-high
- BusOvp_F  in  1  filtered bus OVP, active-low
- IP_Ocp_F  in  1  filtered input OCP, active-low
- InvOcp1_F  in  1  filtered inverter 1 OCP, active-low
- InvOcp2_F  in  1  filtered inverter 2 OCP, active-low
- OP_Ovp1_F  in  1  filtered output 1 OVP, active-low
- OP_Ovp2_F  in  1  filtered output 2 OVP, active-low
- Fault_Clr  in  1  DSP clear request, level, active-high
- PWM_Kill_n  out  1  0 disables all gate drivers
- Fault_n  out  1  0 means a latched fault is pending (DSP interrupt)
- Clr_Ack  out  1  clear accepted, high while in CLEARING
- First_Code  out  3  code of the first fault: 0 none, 1 BusOvp, 2 IP_Ocp, 3 InvOcp1, 4 InvOcp2, 5 OP_Ovp1, 6 OP_Ovp2
- Fault_Mask  out  6  sticky faults; bit k-1 corresponds to code k

Behaviour:
- Clock and reset: single clock CLK_50M. Rst is synchronous and active-high. All outputs are registered.
- Reset values: state HOLDOFF, counters 0, PWM_Kill_n=0, Fault_n=1, Clr_Ack=0, First_Code=0, Fault_Mask=0. The block therefore never starts armed.
- Definitions: act[5:0] is the inverted input vector in code order. Any = |act.

State ARMED (PWM_Kill_n=1, Fault_n=1):
- If Any is seen in cycle N, then in cycle N+1: state TRIPPED, PWM_Kill_n=0, Fault_n=0, Fault_Mask=act.
- First_Code takes the lowest-numbered active code when several faults are simultaneous. Trip latency is exactly 1 clock.

State TRIPPED (PWM_Kill_n=0, Fault_n=0):
- Every cycle Fault_Mask |= act. First_Code is frozen.
- A clear counter increments while Fault_Clr=1, saturates at CLR_MIN, and resets to 0 when Fault_Clr=0.
- When the counter equals CLR_MIN and Any=0, go to CLEARING.
- If Any=1, the clear is ignored and the counter holds at CLR_MIN until the faults go inactive or Fault_Clr drops.

State CLEARING:
- Clr_Ack=1. Fault_Mask=0 and First_Code=0 on entry. PWM_Kill_n stays 0. Fault_n=1.
- Leave to HOLDOFF on the first cycle with Fault_Clr=0.
- If Any=1 while in CLEARING, go to TRIPPED with a fresh latch (same rules as ARMED) and set Clr_Ack=0.

State HOLDOFF:
- PWM_Kill_n=0, Fault_n=1, Clr_Ack=0.
- The counter counts 0..HOLDOFF_CYC-1. After HOLDOFF_CYC cycles go to ARMED; PWM_Kill_n goes 1 on the ARMED entry cycle.
- If Any=1, go to TRIPPED with a fresh latch and reset the counter.
- Fault_Clr is ignored in this state.

Other rules:
- Rst asserted in any state, including mid-CLEARING, forces the reset values on the next edge.
- Unused state encodings recover to TRIPPED with PWM_Kill_n=0 (fail-safe).

Optional Feature:
- Macro: PROTECT_TRIP_CNT_EN.
- Defined: adds an output port Trip_Cnt[7:0] counting ARMED->TRIPPED and HOLDOFF->TRIPPED transitions. It saturates at 255 and is cleared only by Rst.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, then all inputs high -> PWM_Kill_n=0 for 500 cycles after Rst deasserts, then 1; Fault_n=1 throughout.
2. From ARMED, drive InvOcp1_F low for 1 cycle at cycle N -> at N+1: PWM_Kill_n=0, Fault_n=0, First_Code=3, Fault_Mask=6'b000100. The latch holds after the input returns high.
3. From ARMED, drive IP_Ocp_F and OP_Ovp2_F low in the same cycle, then later BusOvp_F -> First_Code=2, Fault_Mask=6'b100011.
4. From TRIPPED, Fault_Clr high for 3 cycles then low -> no Clr_Ack. High for 4 cycles with inputs clear -> Clr_Ack=1 on the 5th cycle, Mask=0, Code=0. Fault_Clr low -> HOLDOFF for 500 cycles -> ARMED.
5. From TRIPPED, Fault_Clr held high with OP_Ovp1_F still low -> stays TRIPPED. When OP_Ovp1_F goes high -> CLEARING on the next cycle.
6. Drive BusOvp_F low at HOLDOFF cycle 200 -> TRIPPED, First_Code=1, Fault_n=0. With PROTECT_TRIP_CNT_EN defined, Trip_Cnt increments by 1.
